// File: rtl/spi_pkg.sv
// Shared definitions for the 10-bit-command SPI master and slave:
// command codes, word widths, the frame state encoding and a helper
// telling which states hold slave select low.
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } spi_state_t;

  // Slave select is asserted for every state between SEL and RECV inclusive.
  function automatic logic ss_active(input spi_state_t s);
    return (s == ST_SEL) || (s == ST_SHIFT) || (s == ST_TURN) || (s == ST_RECV);
  endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// Data path of the SPI master: a 10-bit parallel-load shift-out register
// feeding MOSI and an 8-bit shift-in register collecting MISO. The FSM
// drives it with load/shift/sample/capture strobes.
module spi_master_shreg
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CMD_W-1:0]  load_word,
  input  logic              shift,
  input  logic              sample,
  input  logic              capture,
  input  logic              miso,
  output logic              tx_msb,
  output logic              tx_next,
  output logic [DATA_W-1:0] rd_data
);

  logic [CMD_W-1:0]  sr_tx;
  logic [DATA_W-1:0] sr_rx;

  assign tx_msb  = sr_tx[CMD_W-1];
  assign tx_next = sr_tx[CMD_W-2];

  // Shift-out register: parallel load at launch, then one bit left per shift.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the data registers are reset too; it is cheap here and keeps X off MOSI and rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_tx <= '0;
    end else if (load) begin
      sr_tx <= load_word;
    end else if (shift) begin
      sr_tx <= {sr_tx[CMD_W-2:0], 1'b0};
    end
  end

  // Shift-in register: MSB first; on the last sample the full byte goes to rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_rx   <= '0;
      rd_data <= '0;
    end else begin
      if (sample) begin
        sr_rx <= {sr_rx[DATA_W-2:0], miso};
      end
      if (capture) begin
        rd_data <= {sr_rx[DATA_W-2:0], miso};
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master for the 10-bit-command slave. SCK is the system clock.
// Frame: IDLE -> SEL -> SHIFT(10) -> [TURN(RD_WAIT) -> RECV(8) for cmd 11] -> GAP -> IDLE.
// All outputs are registered and change together with the state register.
// Optional macro SPI_MST_CMD_BUF_EN adds a one-entry command buffer so a
// command can be accepted while a frame is running.
// RD_WAIT and GAP must each lie in 1..7.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd_word,
  output logic              cmd_ready,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  spi_state_t       state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [1:0]       cmd_code;
  logic             launch;
  logic [CMD_W-1:0] launch_word;
  logic             load, shift, sample, capture;
  logic             mosi_nxt;
  logic             tx_msb, tx_next;

`ifdef SPI_MST_CMD_BUF_EN
  logic             buf_valid, buf_valid_nxt;
  logic [CMD_W-1:0] buf_word;
  logic             accept;

  // cmd_ready mirrors "buffer empty"; an accept in IDLE launches directly,
  // anywhere else it parks the command in the buffer.
  assign accept      = cmd_valid & cmd_ready;
  assign launch      = (state == ST_IDLE) & (buf_valid | accept);
  assign launch_word = buf_valid ? buf_word : cmd_word;

  // Buffer occupancy for the next cycle.
  always_comb begin
    buf_valid_nxt = buf_valid;
    if (buf_valid && launch) begin
      buf_valid_nxt = 1'b0;
    end else if (accept && (state != ST_IDLE)) begin
      buf_valid_nxt = 1'b1;
    end
  end

  // Buffer storage and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      cmd_ready <= 1'b1;
    end else begin
      buf_valid <= buf_valid_nxt;
      if (accept && (state != ST_IDLE)) begin
        buf_word <= cmd_word;
      end
      cmd_ready <= ~buf_valid_nxt;
    end
  end
`else
  assign launch      = cmd_valid & cmd_ready & (state == ST_IDLE);
  assign launch_word = cmd_word;

  // Without a buffer the master is ready exactly when it will sit in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
    end else begin
      cmd_ready <= (state_nxt == ST_IDLE);
    end
  end
`endif

  // Next-state, counter reload and data-path strobes.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    shift     = 1'b0;
    sample    = 1'b0;
    capture   = 1'b0;
    mosi_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_nxt = ST_SEL;
          load      = 1'b1;
          mosi_nxt  = launch_word[CMD_W-1];
        end
      end
      ST_SEL: begin
        state_nxt = ST_SHIFT;
        cnt_nxt   = 4'(CMD_W - 1);
        mosi_nxt  = tx_msb;
      end
      ST_SHIFT: begin
        if (cnt == 4'd0) begin
          if (cmd_code == CMD_RD_DATA) begin
            state_nxt = ST_TURN;
            cnt_nxt   = 4'(RD_WAIT - 1);
          end else begin
            state_nxt = ST_GAP;
            cnt_nxt   = 4'(GAP - 1);
          end
        end else begin
          cnt_nxt  = cnt - 4'd1;
          shift    = 1'b1;
          mosi_nxt = tx_next;
        end
      end
      ST_TURN: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RECV;
          cnt_nxt   = 4'(DATA_W - 1);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RECV: begin
        sample = 1'b1;
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = ST_GAP;
          cnt_nxt   = 4'(GAP - 1);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and the registered SPI/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cmd_code <= CMD_WR_ADDR;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (load) begin
        cmd_code <= launch_word[CMD_W-1 -: 2];
      end
      SS_n     <= ~ss_active(state_nxt);
      MOSI     <= mosi_nxt;
      busy     <= (state_nxt != ST_IDLE);
      rd_valid <= capture;
    end
  end

  spi_master_shreg u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_word (launch_word),
    .shift     (shift),
    .sample    (sample),
    .capture   (capture),
    .miso      (MISO),
    .tx_msb    (tx_msb),
    .tx_next   (tx_next),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a small slave model that returns
// slave_byte on MISO during the receive window of a read-data frame.
module tb_spi_master;

  localparam int RD_WAIT = 2;
  localparam int GAP_CYC = 1;
  localparam int RD_LEN  = 11 + RD_WAIT + 8;
`ifdef SPI_MST_CMD_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_word = '0;
  logic       cmd_ready, busy, rd_valid, SS_n, MOSI;
  logic [7:0] rd_data;
  logic       MISO = 1'b0;

  spi_master #(.RD_WAIT(RD_WAIT), .GAP(GAP_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Frame monitor and slave model, both evaluated on the falling edge.
  int          frames = 0, done_frames = 0;
  int          cur_len = 0, last_len = 0;
  logic [31:0] cur_bits = '0, last_bits = '0;
  int          fall_cyc = 0, rise_cyc = 0, last_gap = 0;
  int          rdv_cnt = 0, rdv_cyc = 0;
  int          low_cnt = 0;
  bit          ss_prev = 1'b1;
  logic [7:0]  slave_byte = '0;

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (ss_prev) begin
        frames++;
        fall_cyc = cyc;
        last_gap = cyc - rise_cyc;
        cur_len  = 0;
        cur_bits = '0;
      end
      cur_len++;
      cur_bits = {cur_bits[30:0], MOSI};
      low_cnt++;
    end else begin
      if (!ss_prev) begin
        done_frames++;
        last_len  = cur_len;
        last_bits = cur_bits;
        rise_cyc  = cyc;
      end
      low_cnt = 0;
    end
    ss_prev = (SS_n !== 1'b0);
    if (rd_valid === 1'b1) begin
      rdv_cnt++;
      rdv_cyc = cyc;
    end
    // Slave drives reply bit n (MSB first) in the n-th cycle after TURN.
    if (SS_n === 1'b0 && low_cnt >= 12 + RD_WAIT && low_cnt <= 19 + RD_WAIT)
      MISO = slave_byte[19 + RD_WAIT - low_cnt];
    else
      MISO = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to just after the next falling edge; all sampling happens there.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] w, input bit hold, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_word  = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cmd_ready === 1'b1) ok = 1'b1;
      tick();
    end
    if (ok) acc = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    for (int i = 0; i < 300 && done_frames < target; i++) tick();
    ok = (done_frames >= target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b expected 1", SS_n); end
      checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int acc, f0, r0;
    bit ok;
    f0 = frames;
    r0 = rdv_cnt;
    slave_byte = 8'hFF;
    send(10'b11_0000_0000, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_accept: got timeout expected accept"); end
    // Cycle 1 is SEL; cycle 6 drives command bit 5.
    for (int i = 0; i < 5; i++) tick();
    checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL midrst_in_frame: got SS_n=%b expected 0", SS_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL midrst_ss_async: got %b expected 1", SS_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    checks++; if (rdv_cnt !== r0) begin errors++; $display("FAIL midrst_no_rd_valid: got %0d pulses expected %0d", rdv_cnt - r0, 0); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data_kept: got %h expected 00", rd_data); end
    checks++; if (frames !== f0 + 1) begin errors++; $display("FAIL midrst_no_restart: got %0d frames expected 1", frames - f0); end
  endtask

  task automatic test_write();
    int acc, d0, r0;
    bit ok;
    d0 = done_frames;
    r0 = rdv_cnt;
    send(10'b00_1100_0011, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_accept: got timeout expected accept"); end
    checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL wr_ss_latency: got %b expected 0 one cycle after accept", SS_n); end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_frame_end: got timeout expected SS_n rise"); end
    checks++; if (last_len !== 11) begin errors++; $display("FAIL wr_ss_len: got %0d expected 11", last_len); end
    checks++; if (last_bits[10:0] !== 11'b000_1100_0011) begin errors++; $display("FAIL wr_mosi: got %b expected 00011000011", last_bits[10:0]); end
    for (int i = 0; i < GAP_CYC; i++) begin
      checks++; if (SS_n !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr_gap: got SS_n=%b busy=%b expected 1 1", SS_n, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_idle: got busy=%b ready=%b expected 0 1", busy, cmd_ready); end
    checks++; if (rdv_cnt !== r0) begin errors++; $display("FAIL wr_no_rd_valid: got %0d pulses expected 0", rdv_cnt - r0); end
  endtask

  task automatic test_read(input logic [7:0] b);
    int acc, d0, r0;
    bit ok;
    d0 = done_frames;
    r0 = rdv_cnt;
    slave_byte = b;
    send(10'b11_0000_0000, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_accept: got timeout expected accept"); end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_frame_end: got timeout expected SS_n rise"); end
    checks++; if (last_len !== RD_LEN) begin errors++; $display("FAIL rd_ss_len: got %0d expected %0d", last_len, RD_LEN); end
    checks++; if (last_bits[20:0] !== {11'b111_0000_0000, 10'b0}) begin errors++; $display("FAIL rd_mosi: got %b expected 111000000000000000000", last_bits[20:0]); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (rdv_cnt !== r0 + 1) begin errors++; $display("FAIL rd_valid_count: got %0d pulses expected 1", rdv_cnt - r0); end
    checks++; if (rd_data !== b) begin errors++; $display("FAIL rd_data: got %h expected %h", rd_data, b); end
    checks++; if (rdv_cyc - acc !== RD_LEN) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", rdv_cyc - acc, RD_LEN); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, d0;
    bit ok;
    d0 = done_frames;
    send(10'b01_1010_0101, 1'b1, acc1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept1: got timeout expected accept"); end
    checks++; if (cmd_ready !== BUF_EN) begin errors++; $display("FAIL b2b_ready_in_frame: got %b expected %b", cmd_ready, BUF_EN); end
    send(10'b10_0101_1010, 1'b0, acc2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept2: got timeout expected accept"); end
    wait_done(d0 + 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_frames: got timeout expected two frames"); end
    checks++; if (last_gap !== GAP_CYC + 1) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", last_gap, GAP_CYC + 1); end
    checks++; if (last_len !== 11) begin errors++; $display("FAIL b2b_len2: got %0d expected 11", last_len); end
    checks++; if (last_bits[10:0] !== 11'b110_0101_1010) begin errors++; $display("FAIL b2b_mosi2: got %b expected 11001011010", last_bits[10:0]); end
    tick();
    tick();
  endtask

  task automatic test_busy_ignore();
    int acc, f0;
    bit ok;
    f0 = frames;
    send(10'b01_1111_0000, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_accept: got timeout expected accept"); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_shift: got %b expected 1", busy); end
    checks++; if (cmd_ready !== BUF_EN) begin errors++; $display("FAIL busy_ready: got %b expected %b", cmd_ready, BUF_EN); end
    cmd_valid = 1'b1;
    cmd_word  = 10'b00_0000_0001;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    checks++; if (frames - f0 !== (BUF_EN ? 2 : 1)) begin errors++; $display("FAIL busy_frames: got %0d expected %0d", frames - f0, BUF_EN ? 2 : 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_final_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_write();
    test_read(8'hA5);
    test_read(8'h81);
    test_back_to_back();
    test_busy_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
